mbm_log_mult: RTL and testbench

Pipelined 8x8 unsigned approximate multiplier in the log domain (Mitchell algorithm with minimal-bias correction). Sits directly downstream of the leading-one detectors: takes each operand with its 3-bit leading-one position, forms the fractional mantissas, adds them in the log domain and performs the antilog shift. Valid/ready streaming on both sides with full backpressure; one product per cycle sustained.

---
 rtl/mbm_log_mult_if.sv | 32 +++
 rtl/mbm_log_mult.sv | 167 ++++++++++++++++
 tb/tb_mbm_log_mult.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbm_log_mult_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mbm_log_mult_if                                                  |
// | Purpose : Streaming bus for the log-domain multiplier. Bundles the operand |
// |           input handshake (in_valid/in_ready, a, b, ka, kb) and the        |
// |           product output handshake (out_valid/out_ready, p).               |
// | Modports: master - producer/consumer side (testbench or upstream logic)    |
// |           slave  - the multiplier itself                                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface mbm_log_mult_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  ka;
  logic [2:0]  kb;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;

  modport master (
    output in_valid, a, b, ka, kb, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, ka, kb, out_ready,
    output in_ready, out_valid, p
  );
endinterface
`default_nettype wire

// File: rtl/mbm_log_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mbm_log_mult                                                     |
// | Purpose : 3-stage pipelined 8x8 unsigned approximate multiplier using the  |
// |           Mitchell log-domain method with a minimal-bias correction term.  |
// |           Operands arrive with their leading-one positions; the block      |
// |           forms mantissa fractions, adds them in the log domain and does   |
// |           the antilog shift. Full valid/ready backpressure, 1 result/cycle.|
// | Ports   : clk   - rising-edge clock                                        |
// |           rst_n - asynchronous active-low reset                            |
// |           bus   - slave modport: in_valid/in_ready/a/b/ka/kb in,           |
// |                   out_valid/out_ready/p out                                |
// |           k_err - sticky: an accepted nonzero operand had a wrong ka/kb    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mbm_log_mult #(
  parameter logic [3:0] CORR = 4'd11
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mbm_log_mult_if.slave     bus,
  output logic              k_err
);

  // Pipeline occupancy
  logic        r_v1;
  logic        r_v2;
  logic        r_v3;

  // Stage 1 registers: fractions, exponent sum, zero flag
  logic [6:0]  r1_fa;
  logic [6:0]  r1_fb;
  logic [3:0]  r1_k;
  logic        r1_zero;

  // Stage 2 registers: corrected mantissa and shift amount
  logic [8:0]  r2_m;
  logic [3:0]  r2_sh;
  logic        r2_zero;

  // Stage 3 register: product
  logic [15:0] r_p;
  logic        r_k_err;

  // Advance chain: a stage loads when it is empty or its content moves on.
  logic        w_adv1;
  logic        w_adv2;
  logic        w_adv3;
  logic        w_acc;

  assign w_adv3       = !r_v3 | bus.out_ready;
  assign w_adv2       = !r_v2 | w_adv3;
  assign w_adv1       = !r_v1 | w_adv2;
  // Held low while in reset so nothing is claimed accepted before release.
  assign bus.in_ready = rst_n & w_adv1;
  assign w_acc        = bus.in_valid & bus.in_ready;

  // ---------------- Stage 1 combinational ----------------
  logic        w_za;
  logic        w_zb;
  logic [6:0]  w_fa;
  logic [6:0]  w_fb;
  logic        w_err;

  assign w_za  = (bus.a == 8'd0);
  assign w_zb  = (bus.b == 8'd0);
  // Shifting the leading one up to bit 7 leaves the fraction in bits [6:0].
  assign w_fa  = 7'(bus.a << (3'd7 - bus.ka));
  assign w_fb  = 7'(bus.b << (3'd7 - bus.kb));
  assign w_err = (!w_za && ((bus.a >> bus.ka) != 8'd1)) ||
                 (!w_zb && ((bus.b >> bus.kb) != 8'd1));

  // ---------------- Stage 2 combinational ----------------
  logic [7:0]  w_s;
  logic [8:0]  w_m;
  logic [3:0]  w_sh;

  assign w_s = {1'b0, r1_fa} + {1'b0, r1_fb};

  always_comb begin
    w_m  = 9'd0;
    w_sh = 4'd0;
    if (!w_s[7]) begin
      // No carry out of the fraction sum: restore the implicit leading one.
      w_m  = 9'd128 + {1'b0, w_s} + {5'd0, CORR};
      w_sh = r1_k;
    end else begin
      // Carry already supplies the leading one; bump the exponent instead.
      w_m  = {1'b0, w_s} + {5'd0, CORR};
      w_sh = r1_k + 4'd1;
    end
  end

  // ---------------- Stage 3 combinational ----------------
  // M <= 266 and sh <= 15, so the shifted value always fits in 24 bits.
  logic [23:0] w_shifted;
  logic [16:0] w_q;
  logic [15:0] w_p;

  assign w_shifted = {15'd0, r2_m} << r2_sh;
  assign w_q       = 17'(w_shifted >> 7);

  always_comb begin
    w_p = w_q[15:0];
    if (w_q[16]) begin
      w_p = 16'hFFFF;
    end
    if (r2_zero) begin
      w_p = 16'd0;
    end
  end

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r1_fa   <= 7'd0;
      r1_fb   <= 7'd0;
      r1_k    <= 4'd0;
      r1_zero <= 1'b0;
      r2_m    <= 9'd0;
      r2_sh   <= 4'd0;
      r2_zero <= 1'b0;
      r_p     <= 16'd0;
      r_k_err <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_v1 <= w_acc;
        if (w_acc) begin
          r1_fa   <= w_fa;
          r1_fb   <= w_fb;
          r1_k    <= {1'b0, bus.ka} + {1'b0, bus.kb};
          r1_zero <= w_za | w_zb;
        end
      end

      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r2_m    <= w_m;
          r2_sh   <= w_sh;
          r2_zero <= r1_zero;
        end
      end

      // Product only updates when a real entry lands, so p holds otherwise.
      if (w_adv3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_p <= w_p;
        end
      end

      if (w_acc && w_err) begin
        r_k_err <= 1'b1;
      end
    end
  end

  assign bus.out_valid = r_v3;
  assign bus.p         = r_p;
  assign k_err         = r_k_err;

endmodule
`default_nettype wire

// File: tb/tb_mbm_log_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mbm_log_mult                                                  |
// | Purpose : Self-checking bench for mbm_log_mult. A driver issues operand    |
// |           pairs and queues expected products; a negedge monitor pops and   |
// |           compares on every output transfer and checks stall/ready rules.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mbm_log_mult;

  localparam int CORR_REF = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic k_err;

  mbm_log_mult_if bus ();

  mbm_log_mult #(.CORR(4'd11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .k_err (k_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          acc_cnt = 0;
  int          pop_cnt = 0;
  bit          rnd_ready = 1'b0;
  bit          stall_prev = 1'b0;
  logic [15:0] p_prev = 16'd0;

  // Mitchell product from first principles: value = 2^k * (1 + f/128).
  function automatic logic [15:0] model(int a, int b, int ka, int kb);
    int     fa, fb, s, m, e;
    longint prod;
    if (a == 0 || b == 0) return 16'd0;
    fa = (a * (1 << (7 - ka))) % 128;
    fb = (b * (1 << (7 - kb))) % 128;
    s  = fa + fb;
    if (s < 128) begin
      m = 128 + s + CORR_REF;
      e = ka + kb;
    end else begin
      m = s + CORR_REF;
      e = ka + kb + 1;
    end
    prod = (longint'(m) * (longint'(1) << e)) / 128;
    if (prod > 65535) return 16'hFFFF;
    return 16'(prod);
  endfunction

  function automatic int lod(int v);
    int k = 0;
    for (int i = 0; i < 8; i++) if (v[i]) k = i;
    return k;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the capture edge.
  task automatic send(int a, int b, int ka, int kb, logic [15:0] exp);
    bit acc = 1'b0;
    bit ok  = 1'b0;
    bus.in_valid = 1'b1;
    bus.a  = 8'(a);
    bus.b  = 8'(b);
    bus.ka = 3'(ka);
    bus.kb = 3'(kb);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (ok) begin
      exp_q.push_back(exp);
      acc_cnt++;
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept a=%0d b=%0d", a, b);
    end
  endtask

  task automatic send_rnd();
    int a, b, ka, kb;
    a  = int'($urandom_range(0, 255));
    b  = int'($urandom_range(0, 255));
    ka = (a == 0) ? int'($urandom_range(0, 7)) : lod(a);
    kb = (b == 0) ? int'($urandom_range(0, 7)) : lod(b);
    send(a, b, ka, kb, model(a, b, ka, kb));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", (n < 300) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic latency_probe(string name, int a, int b, int ka, int kb);
    int cnt;
    send(a, b, ka, kb, model(a, b, ka, kb));
    cnt = 1;
    while (!bus.out_valid && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check(name, cnt, 3);
  endtask

  // Randomised consumer.
  always @(posedge clk) begin
    #1;
    if (rnd_ready) bus.out_ready = $urandom_range(0, 1) != 0;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    int occ;
    if (rst_n) begin
      occ = acc_cnt - pop_cnt;
      check("in_ready_rule", bus.in_ready, (occ == 3 && !bus.out_ready) ? 32'd0 : 32'd1);
      if (stall_prev) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_p", bus.p, p_prev);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got p=%0h expected no output", bus.p);
        end else begin
          check("p", bus.p, exp_q.pop_front());
        end
        pop_cnt++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      p_prev     = bus.p;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = 8'd0;
    bus.b         = 8'd0;
    bus.ka        = 3'd0;
    bus.kb        = 3'd0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_p", bus.p, 0);
    check("rst_k_err", k_err, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Zero operand, latency
    latency_probe("latency_zero", 0, 200, 0, 7);
    check("zero_p", bus.p, 0);
    check("zero_k_err", k_err, 0);
    drain();

    // Directed products with hand-computed expectations
    send(1, 1, 0, 0, 16'd1);
    send(16, 8, 4, 3, 16'd139);
    send(3, 3, 1, 1, 16'd8);
    send(255, 255, 7, 7, 16'hFFFF);
    drain();

    // Fill to 3 entries under backpressure, then accept and drain together
    bus.out_ready = 1'b0;
    repeat (3) send_rnd();
    repeat (2) @(posedge clk);
    #1;
    check("full_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    repeat (3) send_rnd();
    drain();

    // Random stream with random backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_rnd();
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
    check("k_err_consistent", k_err, 0);

    // Inconsistent leading-one position
    send(5, 7, 3, 2, model(5, 7, 3, 2));
    check("k_err_rise", k_err, 1);
    repeat (3) send_rnd();
    check("k_err_sticky", k_err, 1);
    drain();
    check("k_err_after_drain", k_err, 1);

    // Reset with three pairs in flight
    bus.out_ready = 1'b0;
    repeat (3) send_rnd();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_p", bus.p, 0);
    check("midrst_k_err", k_err, 0);
    exp_q.delete();
    acc_cnt = 0;
    pop_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    latency_probe("latency_after_rst", 200, 100, 7, 6);
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
